// File: rtl/mips_mem_port_arbiter.sv
// Arbiter sharing one single-ported unified RAM between the IF fetch port and the
// MEM load/store port; fixed-latency reads, posted one-cycle writes, per-stage stalls.
module mips_mem_port_arbiter #(
  parameter int LAT        = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  output logic        if_stall,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_valid,
  output logic        mem_stall,
  output logic        ram_en,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  localparam logic [2:0] CNT_INIT = 3'(LAT - 1);
  localparam logic [3:0] SMAX     = 4'(STARVE_MAX);

  state_t      state, state_nx;
  logic [2:0]  cnt, cnt_nx;
  logic [3:0]  starve, starve_nx;
  logic [31:0] addr_q, wdata_q, addr_mux, wdata_mux;
  logic        done, free, d_req, if_ok, d_ok, grant_i, grant_d, wr_issue;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 3'd0;
      starve  <= 4'd0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      starve  <= starve_nx;
      addr_q  <= addr_mux;
      wdata_q <= wdata_mux;
    end
  end

  always_comb begin
    done  = !reset && (state != IDLE) && (cnt == 3'd0);
    free  = !reset && ((state == IDLE) || done);
    d_req = mem_rd || mem_wr;
    // The side whose read completes this cycle sits out this arbitration round.
    if_ok = if_req && !(done && state == BUSY_I);
    d_ok  = d_req  && !(done && state == BUSY_D);
    grant_i  = free && if_ok && ((starve == SMAX) || !d_ok);
    grant_d  = free && d_ok && !grant_i;
    wr_issue = grant_d && mem_wr;

    addr_mux = addr_q;
    if (grant_i)      addr_mux = if_addr;
    else if (grant_d) addr_mux = mem_addr;
    wdata_mux = wr_issue ? mem_wdata : wdata_q;

    state_nx = state;
    cnt_nx   = cnt;
    if (state != IDLE) begin
      if (done) state_nx = IDLE;
      else      cnt_nx   = cnt - 3'd1;
    end
    if (grant_i) begin
      state_nx = BUSY_I;
      cnt_nx   = CNT_INIT;
    end else if (grant_d && !mem_wr) begin
      state_nx = BUSY_D;
      cnt_nx   = CNT_INIT;
    end

    starve_nx = starve;
    if (grant_i || !if_req)         starve_nx = 4'd0;
    else if (grant_d && starve != SMAX) starve_nx = starve + 4'd1;
  end

  always_comb begin
    if_valid  = done && (state == BUSY_I);
    mem_valid = done && (state == BUSY_D);
    if_rdata  = if_valid  ? ram_rdata : 32'h0;
    mem_rdata = mem_valid ? ram_rdata : 32'h0;
    if_stall  = !reset && if_req && !if_valid;
    mem_stall = !reset && d_req && !(mem_valid || wr_issue);
    ram_en    = grant_i || grant_d;
    ram_we    = wr_issue;
    ram_addr  = reset ? 32'h0 : addr_mux;
    ram_wdata = reset ? 32'h0 : wdata_mux;
  end
endmodule

// File: tb/tb_mips_mem_port_arbiter.sv
// Bench for mips_mem_port_arbiter: timestamp-based reference model checked every cycle,
// directed scenarios with literal expectations, plus a LAT=1 instance for full utilisation.
module tb_mips_mem_port_arbiter;
  localparam int LAT  = 2;
  localparam int SMAX = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0, mem_rd = 1'b0, mem_wr = 1'b0;
  logic [31:0] if_addr = '0, mem_addr = '0, mem_wdata = '0;
  logic [31:0] if_rdata, mem_rdata, ram_addr, ram_wdata, ram_rdata;
  logic        if_valid, if_stall, mem_valid, mem_stall, ram_en, ram_we;

  logic        if_req_b = 1'b0, mem_rd_b = 1'b0, mem_wr_b = 1'b0;
  logic [31:0] if_addr_b = '0, mem_addr_b = '0, mem_wdata_b = '0;
  logic [31:0] if_rdata_b, mem_rdata_b, ram_addr_b, ram_wdata_b;
  logic [31:0] rd_b = '0;
  logic        if_valid_b, if_stall_b, mem_valid_b, mem_stall_b, ram_en_b, ram_we_b;

  int cyc = 0;
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mips_mem_port_arbiter #(.LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid), .mem_stall(mem_stall),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata));

  mips_mem_port_arbiter #(.LAT(1), .STARVE_MAX(SMAX)) dut_b (
    .clk(clk), .reset(reset),
    .if_req(if_req_b), .if_addr(if_addr_b), .if_rdata(if_rdata_b), .if_valid(if_valid_b), .if_stall(if_stall_b),
    .mem_rd(mem_rd_b), .mem_wr(mem_wr_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .mem_rdata(mem_rdata_b), .mem_valid(mem_valid_b), .mem_stall(mem_stall_b),
    .ram_en(ram_en_b), .ram_we(ram_we_b), .ram_addr(ram_addr_b), .ram_wdata(ram_wdata_b), .ram_rdata(rd_b));

  function automatic logic [31:0] init_word(input logic [7:0] idx);
    if (idx == 8'h10) return 32'h8C010004;
    return 32'hA500_0000 | {22'h0, idx, 2'b00};
  endfunction

  // RAM behind the main instance: LAT-deep read pipe, unwritten words read init_word.
  logic [31:0] ram [256];
  logic [255:0] ram_wr = '0;
  logic [31:0] rd_pipe [1:LAT];
  always @(posedge clk) begin
    if (ram_en && ram_we) begin
      ram[ram_addr[9:2]]    <= ram_wdata;
      ram_wr[ram_addr[9:2]] <= 1'b1;
    end
    rd_pipe[1] <= (ram_en && !ram_we) ?
                  (ram_wr[ram_addr[9:2]] ? ram[ram_addr[9:2]] : init_word(ram_addr[9:2])) : 32'h0;
    for (int k = 2; k <= LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign ram_rdata = rd_pipe[LAT];

  always @(posedge clk) rd_b <= (ram_en_b && !ram_we_b) ? (ram_addr_b ^ 32'hFFFF0000) : 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference model: an in-flight read is a (kind, issue cycle) pair; it completes at issue+LAT.
  int          m_kind = 0, m_issue = 0, m_starve = 0;
  logic [31:0] m_addr_q = '0, m_wdata_q = '0, m_rdata = '0;
  logic [31:0] mmem [256];
  logic [255:0] mwr = '0;

  function automatic logic [31:0] mread(input logic [31:0] a);
    return mwr[a[9:2]] ? mmem[a[9:2]] : init_word(a[9:2]);
  endfunction

  initial begin
    logic e_ifv, e_memv, done, free, i_ok, d_ok, gi, gd, e_we;
    logic [31:0] e_addr, e_wdata;
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("rst_ctl", {26'h0, if_valid, if_stall, mem_valid, mem_stall, ram_en, ram_we}, 32'h0);
        chk("rst_addr", ram_addr, 32'h0);
        chk("rst_wdata", ram_wdata, 32'h0);
        m_kind = 0; m_starve = 0; m_addr_q = '0; m_wdata_q = '0;
      end else begin
        done   = (m_kind != 0) && (cyc == m_issue + LAT);
        e_ifv  = done && m_kind == 1;
        e_memv = done && m_kind == 2;
        free   = (m_kind == 0) || done;
        i_ok   = if_req && !e_ifv;
        d_ok   = (mem_rd || mem_wr) && !e_memv;
        gi     = free && i_ok && (m_starve == SMAX || !d_ok);
        gd     = free && d_ok && !gi;
        e_we   = gd && mem_wr;
        e_addr = gi ? if_addr : (gd ? mem_addr : m_addr_q);
        e_wdata = e_we ? mem_wdata : m_wdata_q;
        chk("if_valid", if_valid, e_ifv);
        chk("mem_valid", mem_valid, e_memv);
        chk("if_stall", if_stall, if_req && !e_ifv);
        chk("mem_stall", mem_stall, (mem_rd || mem_wr) && !(e_memv || e_we));
        chk("ram_en", ram_en, gi || gd);
        chk("ram_we", ram_we, e_we);
        chk("ram_addr", ram_addr, e_addr);
        chk("ram_wdata", ram_wdata, e_wdata);
        if (e_ifv)  chk("if_rdata", if_rdata, m_rdata);
        if (e_memv) chk("mem_rdata", mem_rdata, m_rdata);
        if (done) m_kind = 0;
        if (gi) begin
          m_kind = 1; m_issue = cyc; m_rdata = mread(if_addr);
        end else if (gd && !mem_wr) begin
          m_kind = 2; m_issue = cyc; m_rdata = mread(mem_addr);
        end
        if (e_we) begin
          mmem[mem_addr[9:2]] = mem_wdata;
          mwr[mem_addr[9:2]]  = 1'b1;
        end
        if (gi || !if_req) m_starve = 0;
        else if (gd && m_starve < SMAX) m_starve++;
        m_addr_q = e_addr; m_wdata_q = e_wdata;
      end
    end
  end

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  initial begin
    logic [10:0] e_en, e_we4, e_iv4;
    e_en  = 11'b11111011111;
    e_we4 = 11'b01111001111;
    e_iv4 = 11'b00001000000;
    // Requests present during reset must produce nothing.
    if_req = 1; if_addr = 32'h44; mem_wr = 1; mem_addr = 32'h300; mem_wdata = 32'h1234;
    @(negedge clk);
    chk("rst_en_lit", ram_en, 0);
    chk("rst_stall_lit", if_stall, 0);
    nxt(); nxt();
    reset = 0; if_req = 0; mem_wr = 0;
    nxt();

    // T1: lone fetch
    if_req = 1; if_addr = 32'h40;
    @(negedge clk); chk("t1_en0", ram_en, 1); chk("t1_we0", ram_we, 0); chk("t1_stall0", if_stall, 1);
    nxt(); @(negedge clk); chk("t1_stall1", if_stall, 1); chk("t1_v1", if_valid, 0);
    nxt(); @(negedge clk); chk("t1_v2", if_valid, 1); chk("t1_d2", if_rdata, 32'h8C010004);
    chk("t1_stall2", if_stall, 0);
    nxt(); if_req = 0; nxt();

    // T2: load beats fetch; fetch issues in the load's completion cycle
    if_req = 1; if_addr = 32'h80; mem_rd = 1; mem_addr = 32'h100;
    @(negedge clk); chk("t2_en0", ram_en, 1); chk("t2_addr0", ram_addr, 32'h100); chk("t2_we0", ram_we, 0);
    nxt(); nxt(); @(negedge clk);
    chk("t2_mv2", mem_valid, 1); chk("t2_md2", mem_rdata, 32'hA5000100); chk("t2_ms2", mem_stall, 0);
    chk("t2_en2", ram_en, 1); chk("t2_addr2", ram_addr, 32'h80);
    nxt(); mem_rd = 0; @(negedge clk); chk("t2_iv3", if_valid, 0);
    nxt(); @(negedge clk); chk("t2_iv4", if_valid, 1); chk("t2_id4", if_rdata, 32'hA5000080);
    nxt(); if_req = 0; nxt();

    // T3: posted store then fetch, then read the store back
    mem_wr = 1; mem_addr = 32'h104; mem_wdata = 32'hDEADBEEF; if_req = 1; if_addr = 32'h40;
    @(negedge clk); chk("t3_we0", ram_we, 1); chk("t3_ms0", mem_stall, 0); chk("t3_wd0", ram_wdata, 32'hDEADBEEF);
    nxt(); mem_wr = 0;
    @(negedge clk); chk("t3_en1", ram_en, 1); chk("t3_addr1", ram_addr, 32'h40); chk("t3_we1", ram_we, 0);
    nxt(); nxt(); @(negedge clk); chk("t3_iv3", if_valid, 1);
    nxt(); if_req = 0; mem_rd = 1; mem_addr = 32'h104;
    nxt(); nxt(); @(negedge clk); chk("t3_rbv", mem_valid, 1); chk("t3_rbd", mem_rdata, 32'hDEADBEEF);
    nxt(); mem_rd = 0; nxt();

    // T4: back-to-back stores starve the fetch for at most SMAX grants
    if_req = 1; if_addr = 32'h40; mem_wr = 1; mem_addr = 32'h200; mem_wdata = 32'h0BADF00D;
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      chk("t4_en", ram_en, e_en[k]); chk("t4_we", ram_we, e_we4[k]); chk("t4_iv", if_valid, e_iv4[k]);
      nxt();
    end
    mem_wr = 0;
    nxt(); @(negedge clk); chk("t4_iv12", if_valid, 1);
    nxt(); if_req = 0; nxt();

    // T5: reset mid-read abandons the load; the held request re-issues
    mem_rd = 1; mem_addr = 32'h100;
    @(negedge clk); chk("t5_en0", ram_en, 1);
    nxt(); reset = 1;
    @(negedge clk); chk("t5_en1", ram_en, 0); chk("t5_ms1", mem_stall, 0); chk("t5_mv1", mem_valid, 0);
    nxt(); reset = 0;
    @(negedge clk); chk("t5_mv2", mem_valid, 0); chk("t5_en2", ram_en, 1); chk("t5_addr2", ram_addr, 32'h100);
    nxt(); @(negedge clk); chk("t5_mv3", mem_valid, 0);
    nxt(); @(negedge clk); chk("t5_mv4", mem_valid, 1); chk("t5_md4", mem_rdata, 32'hA5000100);
    nxt(); mem_rd = 0; nxt();

    // T6: LAT=1, fetch and load both held -> port busy every cycle, alternating D,I
    if_req_b = 1; if_addr_b = 32'h10; mem_rd_b = 1; mem_addr_b = 32'h20;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("t6_en", ram_en_b, 1);
      chk("t6_we", ram_we_b, 0);
      chk("t6_mv", mem_valid_b, (k % 2) == 1);
      chk("t6_iv", if_valid_b, (k % 2) == 0 && k > 0);
      chk("t6_is", if_stall_b, !((k % 2) == 0 && k > 0));
      chk("t6_ms", mem_stall_b, (k % 2) == 0);
      if (k % 2 == 1)      chk("t6_md", mem_rdata_b, 32'hFFFF0020);
      else if (k > 0)      chk("t6_id", if_rdata_b, 32'hFFFF0010);
      nxt();
    end
    chk("t6_wd", ram_wdata_b, 32'h0);
    if_req_b = 0; mem_rd_b = 0;
    nxt(); nxt(); nxt();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
